lc3_ctrl_fsm: RTL and testbench

LC3_CTRL_FSM -- requirements
Module: lc3_ctrl_fsm

---
 rtl/lc3_pkg.sv | 139 +++++++++++++
 rtl/lc3_ctrl_fsm_if.sv | 36 +++
 rtl/mem_wait_ctr.sv | 36 +++
 rtl/lc3_ctrl_fsm.sv | 244 ++++++++++++++++++++++++
 tb/tb_lc3_ctrl_fsm.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_pkg.sv
// LC-3 control FSM shared types: control bundle, state encoding,
// opcodes and datapath mux select encodings.
package lc3_pkg;

  localparam int CTR_W = 3;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_LD    = 4'b0010;
  localparam logic [3:0] OP_ST    = 4'b0011;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_RTI   = 4'b1000;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_LDI   = 4'b1010;
  localparam logic [3:0] OP_STI   = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;
  localparam logic [3:0] OP_LEA   = 4'b1110;
  localparam logic [3:0] OP_TRAP  = 4'b1111;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic DRMUX_IR = 1'b0;
  localparam logic DRMUX_R7 = 1'b1;

  // SR1 from IR[11:9] (HI) or IR[8:6] (LO)
  localparam logic SR1_HI = 1'b0;
  localparam logic SR1_LO = 1'b1;

  localparam logic ADDR1_PC    = 1'b0;
  localparam logic ADDR1_BASER = 1'b1;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic MARMUX_ZEXT  = 1'b0;
  localparam logic MARMUX_ADDER = 1'b1;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  typedef struct packed {
    logic       LD_MAR;
    logic       LD_MDR;
    logic       LD_IR;
    logic       LD_BEN;
    logic       LD_REG;
    logic       LD_CC;
    logic       LD_PC;
    logic       LD_LED;
    logic       GatePC;
    logic       GateMDR;
    logic       GateALU;
    logic       GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX;
    logic       SR1MUX;
    logic       ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic       MARMUX;
    logic       SR2MUX;
    logic [1:0] ALUK;
    logic       MIO_EN;
  } ctrl_t;

  typedef enum logic [5:0] {
    S_HALTED,
    S_F18,
    S_RD_F,
    S_F35,
    S_D32,
    S_ADD,
    S_AND,
    S_NOT,
    S_LD,
    S_LDR,
    S_LDI,
    S_RD_LDI,
    S_LDI_MAR,
    S_RD_LD,
    S_LD_DR,
    S_ST,
    S_STR,
    S_STI,
    S_RD_STI,
    S_STI_MAR,
    S_ST_MDR,
    S_WR,
    S_LEA,
    S_JMP,
    S_JSR_R7,
    S_JSR_OFF,
    S_JSRR,
    S_BR,
    S_BR_TAKEN,
    S_TRAP,
    S_TRAP_R7,
    S_RD_TRAP,
    S_TRAP_PC,
    S_P1,
    S_P2
  } state_e;

  function automatic logic is_rd(state_e s);
    return s inside {S_RD_F, S_RD_LD, S_RD_LDI,
                     S_RD_STI, S_RD_TRAP};
  endfunction

  // Successor for the fixed linear steps of memory sequences
  function automatic state_e seq_next(state_e s);
    seq_next = S_F18;
    case (s)
      S_RD_F:    seq_next = S_F35;
      S_LD:      seq_next = S_RD_LD;
      S_LDR:     seq_next = S_RD_LD;
      S_LDI:     seq_next = S_RD_LDI;
      S_RD_LDI:  seq_next = S_LDI_MAR;
      S_LDI_MAR: seq_next = S_RD_LD;
      S_RD_LD:   seq_next = S_LD_DR;
      S_ST:      seq_next = S_ST_MDR;
      S_STR:     seq_next = S_ST_MDR;
      S_STI:     seq_next = S_RD_STI;
      S_RD_STI:  seq_next = S_STI_MAR;
      S_STI_MAR: seq_next = S_ST_MDR;
      S_RD_TRAP: seq_next = S_TRAP_PC;
      default:   seq_next = S_F18;
    endcase
  endfunction

endpackage

// File: rtl/lc3_ctrl_fsm_if.sv
// Datapath/SRAM side of the LC-3 control FSM: instruction and
// branch inputs, control bundle and SRAM selects/strobes.
interface lc3_ctrl_fsm_if;
  import lc3_pkg::*;

  logic [15:0] IR;
  logic        BEN;
  ctrl_t       Ctrl;
  logic        Mem_CE;
  logic        Mem_UB;
  logic        Mem_LB;
  logic        Mem_OE;
  logic        Mem_WE;

  modport master (
    input  IR,
    input  BEN,
    output Ctrl,
    output Mem_CE,
    output Mem_UB,
    output Mem_LB,
    output Mem_OE,
    output Mem_WE
  );

  modport slave (
    output IR,
    output BEN,
    input  Ctrl,
    input  Mem_CE,
    input  Mem_UB,
    input  Mem_LB,
    input  Mem_OE,
    input  Mem_WE
  );
endinterface

// File: rtl/mem_wait_ctr.sv
// Shared SRAM wait-cycle down-counter; load wins over decrement,
// decrement saturates at zero.
module mem_wait_ctr
  import lc3_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CTR_W-1:0] val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CTR_W-1:0] cnt_q;
  logic [CTR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 microsequencer: fetch/decode/execute FSM driving datapath
// controls and asynchronous SRAM strobes.
module lc3_ctrl_fsm
  import lc3_pkg::*;
#(
  parameter int MEM_RD_WAIT = 2,
  parameter int MEM_WR_WAIT = 2,
  parameter bit PAUSE_EN    = 1'b1
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Run,
  input  logic           Continue,
  lc3_ctrl_fsm_if.master bus,
  output logic           Halted
);

  localparam logic [CTR_W-1:0] RD_LD = CTR_W'(MEM_RD_WAIT - 1);
  localparam logic [CTR_W-1:0] WR_LD = CTR_W'(MEM_WR_WAIT - 1);

  state_e           state_q;
  state_e           state_d;
  ctrl_t            ctrl;
  logic             oe_n;
  logic             we_n;
  logic             ctr_load;
  logic             ctr_dec;
  logic             ctr_zero;
  logic [CTR_W-1:0] ctr_val;
  logic [3:0]       op;

  assign op = bus.IR[15:12];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_HALTED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    oe_n    = 1'b1;
    we_n    = 1'b1;
    unique case (state_q)
      S_HALTED: begin
        if (Run) state_d = S_F18;
      end
      S_F18: begin
        ctrl.LD_MAR = 1'b1;
        ctrl.GatePC = 1'b1;
        ctrl.LD_PC  = 1'b1;
        ctrl.PCMUX  = PCMUX_INC;
        state_d     = S_RD_F;
      end
      S_RD_F, S_RD_LD, S_RD_LDI, S_RD_STI, S_RD_TRAP: begin
        oe_n = 1'b0;
        if (ctr_zero) begin
          ctrl.LD_MDR = 1'b1;
          ctrl.MIO_EN = 1'b1;
          state_d     = seq_next(state_q);
        end
      end
      S_F35: begin
        ctrl.LD_IR   = 1'b1;
        ctrl.GateMDR = 1'b1;
        state_d      = S_D32;
      end
      S_D32: begin
        ctrl.LD_BEN = 1'b1;
        case (op)
          OP_BR:   state_d = S_BR;
          OP_ADD:  state_d = S_ADD;
          OP_LD:   state_d = S_LD;
          OP_ST:   state_d = S_ST;
          OP_JSR:  state_d = S_JSR_R7;
          OP_AND:  state_d = S_AND;
          OP_LDR:  state_d = S_LDR;
          OP_STR:  state_d = S_STR;
          OP_NOT:  state_d = S_NOT;
          OP_LDI:  state_d = S_LDI;
          OP_STI:  state_d = S_STI;
          OP_JMP:  state_d = S_JMP;
          OP_LEA:  state_d = S_LEA;
          OP_TRAP: state_d = S_TRAP;
          OP_PAUSE: begin
            if (PAUSE_EN) begin
              ctrl.LD_LED = 1'b1;
              state_d     = S_P1;
            end else begin
              state_d = S_F18;
            end
          end
          default: state_d = S_F18;
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        ctrl.LD_REG  = 1'b1;
        ctrl.LD_CC   = 1'b1;
        ctrl.GateALU = 1'b1;
        ctrl.SR1MUX  = SR1_LO;
        ctrl.DRMUX   = DRMUX_IR;
        ctrl.SR2MUX  = (state_q != S_NOT) && bus.IR[5];
        ctrl.ALUK    = (state_q == S_ADD) ? ALUK_ADD :
                       (state_q == S_AND) ? ALUK_AND :
                                            ALUK_NOT;
        state_d      = S_F18;
      end
      S_LD, S_LDI, S_ST, S_STI: begin
        ctrl.LD_MAR     = 1'b1;
        ctrl.GateMARMUX = 1'b1;
        ctrl.MARMUX     = MARMUX_ADDER;
        ctrl.ADDR1MUX   = ADDR1_PC;
        ctrl.ADDR2MUX   = ADDR2_OFF9;
        state_d         = seq_next(state_q);
      end
      S_LDR, S_STR: begin
        ctrl.LD_MAR     = 1'b1;
        ctrl.GateMARMUX = 1'b1;
        ctrl.MARMUX     = MARMUX_ADDER;
        ctrl.SR1MUX     = SR1_LO;
        ctrl.ADDR1MUX   = ADDR1_BASER;
        ctrl.ADDR2MUX   = ADDR2_OFF6;
        state_d         = seq_next(state_q);
      end
      S_LDI_MAR, S_STI_MAR: begin
        ctrl.LD_MAR  = 1'b1;
        ctrl.GateMDR = 1'b1;
        state_d      = seq_next(state_q);
      end
      S_LD_DR: begin
        ctrl.LD_REG  = 1'b1;
        ctrl.LD_CC   = 1'b1;
        ctrl.GateMDR = 1'b1;
        ctrl.DRMUX   = DRMUX_IR;
        state_d      = S_F18;
      end
      S_ST_MDR: begin
        // MIO_EN stays 0 so MDR takes the bus, not the SRAM
        ctrl.LD_MDR  = 1'b1;
        ctrl.GateALU = 1'b1;
        ctrl.ALUK    = ALUK_PASSA;
        ctrl.SR1MUX  = SR1_HI;
        state_d      = S_WR;
      end
      S_WR: begin
        we_n = 1'b0;
        if (ctr_zero) state_d = S_F18;
      end
      S_LEA: begin
        ctrl.LD_REG     = 1'b1;
        ctrl.LD_CC      = 1'b1;
        ctrl.GateMARMUX = 1'b1;
        ctrl.MARMUX     = MARMUX_ADDER;
        ctrl.ADDR1MUX   = ADDR1_PC;
        ctrl.ADDR2MUX   = ADDR2_OFF9;
        ctrl.DRMUX      = DRMUX_IR;
        state_d         = S_F18;
      end
      S_JMP, S_JSRR: begin
        ctrl.LD_PC    = 1'b1;
        ctrl.PCMUX    = PCMUX_ADDER;
        ctrl.SR1MUX   = SR1_LO;
        ctrl.ADDR1MUX = ADDR1_BASER;
        ctrl.ADDR2MUX = ADDR2_ZERO;
        state_d       = S_F18;
      end
      S_JSR_R7: begin
        ctrl.LD_REG = 1'b1;
        ctrl.DRMUX  = DRMUX_R7;
        ctrl.GatePC = 1'b1;
        state_d     = bus.IR[11] ? S_JSR_OFF : S_JSRR;
      end
      S_JSR_OFF: begin
        ctrl.LD_PC    = 1'b1;
        ctrl.PCMUX    = PCMUX_ADDER;
        ctrl.ADDR1MUX = ADDR1_PC;
        ctrl.ADDR2MUX = ADDR2_OFF11;
        state_d       = S_F18;
      end
      S_BR: begin
        state_d = bus.BEN ? S_BR_TAKEN : S_F18;
      end
      S_BR_TAKEN: begin
        ctrl.LD_PC    = 1'b1;
        ctrl.PCMUX    = PCMUX_ADDER;
        ctrl.ADDR1MUX = ADDR1_PC;
        ctrl.ADDR2MUX = ADDR2_OFF9;
        state_d       = S_F18;
      end
      S_TRAP: begin
        ctrl.LD_MAR     = 1'b1;
        ctrl.GateMARMUX = 1'b1;
        ctrl.MARMUX     = MARMUX_ZEXT;
        state_d         = S_TRAP_R7;
      end
      S_TRAP_R7: begin
        ctrl.LD_REG = 1'b1;
        ctrl.DRMUX  = DRMUX_R7;
        ctrl.GatePC = 1'b1;
        state_d     = S_RD_TRAP;
      end
      S_TRAP_PC: begin
        ctrl.LD_PC   = 1'b1;
        ctrl.PCMUX   = PCMUX_BUS;
        ctrl.GateMDR = 1'b1;
        state_d      = S_F18;
      end
      S_P1: begin
        if (Continue) state_d = S_P2;
      end
      S_P2: begin
        if (!Continue) state_d = S_F18;
      end
      default: state_d = S_HALTED;
    endcase
  end

  // Reload on entry to any strobe state; count down while inside
  assign ctr_load = (state_d != state_q) &&
                    (is_rd(state_d) || (state_d == S_WR));
  assign ctr_val  = (state_d == S_WR) ? WR_LD : RD_LD;
  assign ctr_dec  = is_rd(state_q) || (state_q == S_WR);

  mem_wait_ctr u_ctr (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .load_i (ctr_load),
    .val_i  (ctr_val),
    .dec_i  (ctr_dec),
    .zero_o (ctr_zero)
  );

  assign bus.Ctrl   = ctrl;
  assign bus.Mem_OE = oe_n;
  assign bus.Mem_WE = we_n;
  assign bus.Mem_CE = 1'b0;
  assign bus.Mem_UB = 1'b0;
  assign bus.Mem_LB = 1'b0;
  assign Halted     = (state_q == S_HALTED);

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Directed bench for lc3_ctrl_fsm: per-cycle expected strobe/load
// words are queued and compared against two DUT configurations.
module tb_lc3_ctrl_fsm;
  import lc3_pkg::*;

  // {Halted, ~OE, ~WE, MAR, MDR, IR, BEN, REG, CC, PC, LED, MIO}
  localparam logic [11:0] O_IDLE = 12'h000;
  localparam logic [11:0] O_HALT = 12'h800;
  localparam logic [11:0] O_F18  = 12'h104;
  localparam logic [11:0] O_RD   = 12'h400;
  localparam logic [11:0] O_RDL  = 12'h481;
  localparam logic [11:0] O_F35  = 12'h040;
  localparam logic [11:0] O_D32  = 12'h020;
  localparam logic [11:0] O_LED  = 12'h022;
  localparam logic [11:0] O_ALU  = 12'h018;
  localparam logic [11:0] O_MAR  = 12'h100;
  localparam logic [11:0] O_MDR  = 12'h080;
  localparam logic [11:0] O_WR   = 12'h200;
  localparam logic [11:0] O_PC   = 12'h004;
  localparam logic [11:0] O_REG  = 12'h010;

  typedef struct {
    bit          sel;
    logic [11:0] exp;
    string       tag;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        rst_b;
  logic        run;
  logic        cont;
  logic        ben;
  logic [15:0] ir;
  logic        halt_a;
  logic        halt_b;
  bit          dsel;
  string       phase;
  int          checks = 0;
  int          errors = 0;
  sb_t         sbq[$];

  always #5 clk = ~clk;

  lc3_ctrl_fsm_if bus_a ();
  lc3_ctrl_fsm_if bus_b ();

  assign bus_a.IR  = ir;
  assign bus_a.BEN = ben;
  assign bus_b.IR  = ir;
  assign bus_b.BEN = ben;

  lc3_ctrl_fsm #(
    .MEM_RD_WAIT (2),
    .MEM_WR_WAIT (2),
    .PAUSE_EN    (1'b1)
  ) dut_a (
    .Clk      (clk),
    .Reset_n  (rst_a),
    .Run      (run),
    .Continue (cont),
    .bus      (bus_a),
    .Halted   (halt_a)
  );

  lc3_ctrl_fsm #(
    .MEM_RD_WAIT (3),
    .MEM_WR_WAIT (4),
    .PAUSE_EN    (1'b1)
  ) dut_b (
    .Clk      (clk),
    .Reset_n  (rst_b),
    .Run      (run),
    .Continue (cont),
    .bus      (bus_b),
    .Halted   (halt_b)
  );

  function automatic logic [11:0] obs_of(logic h, logic oe,
                                         logic we, ctrl_t c);
    return {h, ~oe, ~we, c.LD_MAR, c.LD_MDR, c.LD_IR, c.LD_BEN,
            c.LD_REG, c.LD_CC, c.LD_PC, c.LD_LED, c.MIO_EN};
  endfunction

  wire [11:0] obs_a = obs_of(halt_a, bus_a.Mem_OE,
                             bus_a.Mem_WE, bus_a.Ctrl);
  wire [11:0] obs_b = obs_of(halt_b, bus_b.Mem_OE,
                             bus_b.Mem_WE, bus_b.Ctrl);

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      sb_t e;
      logic [11:0] got;
      e   = sbq.pop_front();
      got = e.sel ? obs_b : obs_a;
      checks++;
      assert (got === e.exp) else begin
        errors++;
        $error("FAIL sb_%s: observed %h expected %h",
               e.tag, got, e.exp);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [11:0] e);
    sbq.push_back('{dsel, e, phase});
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int w);
    repeat (w - 1) cyc(O_RD);
    cyc(O_RDL);
  endtask

  task automatic fetch(input logic [15:0] i, input int w,
                       input logic [11:0] d);
    ir = i;
    cyc(O_F18);
    rd(w);
    cyc(O_F35);
    cyc(d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    run   = 1'b0;
    cont  = 1'b0;
    ben   = 1'b0;
    ir    = 16'h0000;
    dsel  = 1'b0;
    phase = "reset";
    @(posedge clk);
    #1;
    chk("rst_ctrl", 32'(bus_a.Ctrl), 32'h0);
    chk("rst_strobes", {bus_a.Mem_OE, bus_a.Mem_WE}, 2'b11);
    chk("rst_sel", {bus_a.Mem_CE, bus_a.Mem_UB, bus_a.Mem_LB}, 3'b000);
    cyc(O_HALT);
    rst_a = 1'b1;
    phase = "idle";
    repeat (3) cyc(O_HALT);
    run = 1'b1;
    cyc(O_HALT);
    run = 1'b0;

    phase = "add";
    fetch(16'h1261, 2, O_D32);
    chk("add_aluk", bus_a.Ctrl.ALUK, 2'b00);
    chk("add_sr2", bus_a.Ctrl.SR2MUX, 1'b1);
    chk("add_gate", bus_a.Ctrl.GateALU, 1'b1);
    cyc(O_ALU);

    phase = "and";
    run = 1'b1;
    fetch(16'h5260, 2, O_D32);
    chk("and_aluk", bus_a.Ctrl.ALUK, 2'b01);
    cyc(O_ALU);
    run = 1'b0;

    phase = "not";
    fetch(16'h927F, 2, O_D32);
    chk("not_aluk", bus_a.Ctrl.ALUK, 2'b10);
    cyc(O_ALU);

    phase = "br_taken";
    ben = 1'b1;
    fetch(16'h0402, 2, O_D32);
    cyc(O_IDLE);
    chk("br_pcmux", bus_a.Ctrl.PCMUX, PCMUX_ADDER);
    chk("br_addr2", bus_a.Ctrl.ADDR2MUX, ADDR2_OFF9);
    chk("br_addr1", bus_a.Ctrl.ADDR1MUX, ADDR1_PC);
    cyc(O_PC);

    phase = "br_not";
    ben = 1'b0;
    fetch(16'h0402, 2, O_D32);
    cyc(O_IDLE);

    phase = "lea";
    fetch(16'hE5FF, 2, O_D32);
    chk("lea_marmux", {bus_a.Ctrl.GateMARMUX, bus_a.Ctrl.MARMUX},
        {1'b1, MARMUX_ADDER});
    cyc(O_ALU);

    phase = "jmp";
    fetch(16'hC1C0, 2, O_D32);
    chk("jmp_addr1", bus_a.Ctrl.ADDR1MUX, ADDR1_BASER);
    cyc(O_PC);

    phase = "jsr";
    fetch(16'h4802, 2, O_D32);
    chk("jsr_r7", {bus_a.Ctrl.DRMUX, bus_a.Ctrl.GatePC},
        {DRMUX_R7, 1'b1});
    cyc(O_REG);
    chk("jsr_addr2", bus_a.Ctrl.ADDR2MUX, ADDR2_OFF11);
    cyc(O_PC);

    phase = "jsrr";
    fetch(16'h4080, 2, O_D32);
    cyc(O_REG);
    chk("jsrr_addr1", bus_a.Ctrl.ADDR1MUX, ADDR1_BASER);
    cyc(O_PC);

    phase = "trap";
    fetch(16'hF025, 2, O_D32);
    chk("trap_marmux", bus_a.Ctrl.MARMUX, MARMUX_ZEXT);
    cyc(O_MAR);
    cyc(O_REG);
    rd(2);
    chk("trap_pcmux", bus_a.Ctrl.PCMUX, PCMUX_BUS);
    cyc(O_PC);

    phase = "rst_rd";
    cyc(O_F18);
    chk("pre_rst_oe", bus_a.Mem_OE, 1'b0);
    rst_a = 1'b0;
    #1;
    chk("rst_rd_oe", bus_a.Mem_OE, 1'b1);
    chk("rst_rd_halt", halt_a, 1'b1);
    @(posedge clk);
    #1;

    dsel  = 1'b1;
    rst_b = 1'b1;
    phase = "b_start";
    cyc(O_HALT);
    run = 1'b1;
    cyc(O_HALT);
    run = 1'b0;

    phase = "ldi";
    fetch(16'hA002, 3, O_D32);
    cyc(O_MAR);
    rd(3);
    chk("ldi_gatemdr", bus_b.Ctrl.GateMDR, 1'b1);
    cyc(O_MAR);
    rd(3);
    cyc(O_ALU);

    phase = "str";
    fetch(16'h7440, 3, O_D32);
    cyc(O_MAR);
    chk("str_aluk", bus_b.Ctrl.ALUK, 2'b11);
    cyc(O_MDR);
    repeat (4) cyc(O_WR);

    phase = "ld";
    fetch(16'h2005, 3, O_D32);
    cyc(O_MAR);
    rd(3);
    cyc(O_ALU);

    phase = "sti";
    fetch(16'hB003, 3, O_D32);
    cyc(O_MAR);
    rd(3);
    cyc(O_MAR);
    cyc(O_MDR);
    repeat (4) cyc(O_WR);

    phase = "rti";
    fetch(16'h8000, 3, O_D32);

    phase = "pause";
    fetch(16'hD0FF, 3, O_LED);
    repeat (100) cyc(O_IDLE);
    cont = 1'b1;
    repeat (3) cyc(O_IDLE);
    cont = 1'b0;
    cyc(O_IDLE);

    phase = "st_rst";
    fetch(16'h3000, 3, O_D32);
    cyc(O_MAR);
    cyc(O_MDR);
    cyc(O_WR);
    cyc(O_WR);
    chk("pre_rst_we", bus_b.Mem_WE, 1'b0);
    rst_b = 1'b0;
    #1;
    chk("rst_wr_we", bus_b.Mem_WE, 1'b1);
    chk("rst_wr_oe", bus_b.Mem_OE, 1'b1);
    chk("rst_wr_halt", halt_b, 1'b1);
    chk("rst_wr_ctrl", 32'(bus_b.Ctrl), 32'h0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    phase = "restart";
    repeat (3) cyc(O_HALT);
    run = 1'b1;
    cyc(O_HALT);
    run = 1'b0;
    fetch(16'h1201, 3, O_D32);
    chk("add_sr2_imm0", bus_b.Ctrl.SR2MUX, 1'b0);
    cyc(O_ALU);
    cyc(O_F18);

    @(negedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
